// File: rtl/zbt_mem_arbiter.sv
// Three-way arbiter for the shared pipelined ZBT frame memory: VGA reads (strict priority),
// NTSC writes and transform-engine reads/writes (round-robin). FRAME_SWAP_EN enables double buffering.
`timescale 1ns/1ps

// grant source | meaning
// SRC_NONE     | no operation issued this cycle
// SRC_VGA      | VGA read (bypass from vga_flag)
// SRC_NTSC     | NTSC capture write
// SRC_PT       | transform engine read or write
module zbt_mem_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 36,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_flag,
  input  logic              vga_flag,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              done_vga,
  output logic              vga_overrun,
  input  logic              ntsc_flag,
  input  logic [ADDR_W-1:0] ntsc_addr,
  input  logic [DATA_W-1:0] ntsc_data,
  output logic              done_ntsc,
  input  logic              pt_flag,
  input  logic              pt_we,
  input  logic [ADDR_W-1:0] pt_addr,
  input  logic [DATA_W-1:0] pt_wdata,
  output logic [DATA_W-1:0] pt_rdata,
  output logic              done_pt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cen,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {SRC_NONE, SRC_VGA, SRC_NTSC, SRC_PT} src_t;

  src_t               win;
  logic               vga_pend;
  logic               pt_busy;
  logic               rr_pt;
  logic               iss_vga;
  logic               iss_pt;
  logic [MEM_LAT-1:0] tag_vga;
  logic [MEM_LAT-1:0] tag_pt;
  logic               ntsc_ok;
  logic               pt_ok;
  logic [ADDR_W-1:0]  vga_eff;
  logic [ADDR_W-1:0]  ntsc_eff;
  logic [ADDR_W-1:0]  pt_eff;

`ifdef FRAME_SWAP_EN
  logic bank;

  // Display and transform reads use the shown bank; all writes go to the one being built.
  always_comb begin
    vga_eff            = vga_addr;
    vga_eff[ADDR_W-1]  = bank;
    ntsc_eff           = ntsc_addr;
    ntsc_eff[ADDR_W-1] = ~bank;
    pt_eff             = pt_addr;
    pt_eff[ADDR_W-1]   = bank ^ pt_we;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank <= 1'b0;
    end else if (frame_flag) begin
      bank <= ~bank;
    end
  end
`else
  logic unused_frame;

  assign unused_frame = frame_flag;
  assign vga_eff      = vga_addr;
  assign ntsc_eff     = ntsc_addr;
  assign pt_eff       = pt_addr;
`endif

  // A requester is not eligible in the cycle its done is visible, since its flag is still held then.
  assign ntsc_ok = ntsc_flag & ~done_ntsc;
  assign pt_ok   = pt_flag & ~pt_busy & ~done_pt;

  always_comb begin
    win = SRC_NONE;
    if (vga_flag && !vga_pend) begin
      win = SRC_VGA;
    end else if (ntsc_ok && pt_ok) begin
      win = rr_pt ? SRC_PT : SRC_NTSC;
    end else if (ntsc_ok) begin
      win = SRC_NTSC;
    end else if (pt_ok) begin
      win = SRC_PT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      mem_cen     <= 1'b0;
      vga_pixel   <= '0;
      done_vga    <= 1'b0;
      vga_overrun <= 1'b0;
      done_ntsc   <= 1'b0;
      pt_rdata    <= '0;
      done_pt     <= 1'b0;
      vga_pend    <= 1'b0;
      pt_busy     <= 1'b0;
      rr_pt       <= 1'b0;
      iss_vga     <= 1'b0;
      iss_pt      <= 1'b0;
      tag_vga     <= '0;
      tag_pt      <= '0;
    end else begin
      mem_cen   <= (win != SRC_NONE);
      mem_we    <= (win == SRC_NTSC) || ((win == SRC_PT) && pt_we);
      iss_vga   <= (win == SRC_VGA);
      iss_pt    <= (win == SRC_PT) && !pt_we;
      done_ntsc <= (win == SRC_NTSC);

      case (win)
        SRC_VGA: mem_addr <= vga_eff;
        SRC_NTSC: begin
          mem_addr  <= ntsc_eff;
          mem_wdata <= ntsc_data;
          rr_pt     <= 1'b1;
        end
        SRC_PT: begin
          mem_addr <= pt_eff;
          if (pt_we) mem_wdata <= pt_wdata;
          rr_pt <= 1'b0;
        end
        default: ;
      endcase

      // The issue register is stage zero, so tag[MEM_LAT-1] lines up with valid mem_rdata.
      tag_vga[0] <= iss_vga;
      tag_pt[0]  <= iss_pt;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vga[i] <= tag_vga[i-1];
        tag_pt[i]  <= tag_pt[i-1];
      end

      if (tag_vga[MEM_LAT-1]) vga_pixel <= mem_rdata;
      done_vga <= tag_vga[MEM_LAT-1];
      if (tag_pt[MEM_LAT-1]) pt_rdata <= mem_rdata;
      done_pt <= tag_pt[MEM_LAT-1] || ((win == SRC_PT) && pt_we);

      if (win == SRC_VGA) begin
        vga_pend <= 1'b1;
      end else if (tag_vga[MEM_LAT-1]) begin
        vga_pend <= 1'b0;
      end
      if (vga_flag && vga_pend) vga_overrun <= 1'b1;

      if ((win == SRC_PT) && !pt_we) begin
        pt_busy <= 1'b1;
      end else if (done_pt) begin
        pt_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zbt_mem_arbiter.sv
// Scoreboard bench for zbt_mem_arbiter: a request-level model predicts every memory issue and done.
`timescale 1ns/1ps

module tb_zbt_mem_arbiter;
  localparam int AW  = 19;
  localparam int DW  = 36;
  localparam int LAT = 2;
`ifdef FRAME_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          frame_flag, vga_flag, ntsc_flag, pt_flag, pt_we;
  logic [AW-1:0] vga_addr, ntsc_addr, pt_addr;
  logic [DW-1:0] ntsc_data, pt_wdata;
  logic [DW-1:0] vga_pixel, pt_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          done_vga, vga_overrun, done_ntsc, done_pt, mem_we, mem_cen;
  logic [AW-1:0] mem_addr;

  zbt_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag),
    .vga_flag(vga_flag), .vga_addr(vga_addr), .vga_pixel(vga_pixel),
    .done_vga(done_vga), .vga_overrun(vga_overrun),
    .ntsc_flag(ntsc_flag), .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data), .done_ntsc(done_ntsc),
    .pt_flag(pt_flag), .pt_we(pt_we), .pt_addr(pt_addr), .pt_wdata(pt_wdata),
    .pt_rdata(pt_rdata), .done_pt(done_pt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_cen(mem_cen),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic rd; logic [DW-1:0] data; } done_exp_t;
  mem_exp_t  q_mem[$];
  done_exp_t q_vga[$];
  done_exp_t q_pt[$];
  int        q_nd[$];

  // Memory contents are a fixed function of address, so read data is known from the address alone.
  function automatic logic [DW-1:0] hashf(logic [AW-1:0] a);
    logic [DW-1:0] h;
    h = {a[16:0], ~a};
    return h ^ 36'h5A5A5A5A5;
  endfunction

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom);
  endfunction

  function automatic logic [DW-1:0] rdat();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Memory device: answers reads LAT cycles after the DUT presents them.
  int            rd_at [0:7] = '{default: -1};
  logic [DW-1:0] rd_d  [0:7];
  always @(negedge clock) begin
    if (mem_cen === 1'b1 && mem_we === 1'b0) begin
      rd_at[(cyc + LAT) % 8] = cyc + LAT;
      rd_d[(cyc + LAT) % 8]  = hashf(mem_addr);
    end
  end
  always @(posedge clock) begin
    #1;
    if (rd_at[cyc % 8] == cyc) mem_rdata = rd_d[cyc % 8];
    else mem_rdata = rdat();
  end

  // Reference model state, at the level of whole requests.
  int            vga_last = -100;
  int            ovr_cyc  = -1;
  bit            last_pt  = 1'b1;
  bit            m_bank   = 1'b0;
  bit            n_on     = 1'b0;
  int            n_gc     = -1;
  int            n_seq    = 0;
  logic [AW-1:0] n_addr;
  logic [DW-1:0] n_data;
  bit            p_on     = 1'b0;
  int            p_done   = -1;
  logic          p_wr;
  logic [AW-1:0] p_addr_m;
  logic [DW-1:0] p_wd;

  function automatic logic [AW-1:0] eff(logic [AW-1:0] a, logic wr);
    logic [AW-1:0] r;
    r = a;
    r[AW-1] = SWAP ? (m_bank ^ wr) : a[AW-1];
    return r;
  endfunction

  task automatic drive_one(int mode, int k);
    int            c;
    int            win;
    bit            wn, wp, vf, ff, vpend, n_ok, p_ok;
    logic [AW-1:0] va, ea;
    c = cyc;
    if (n_on && n_gc >= 0 && c >= n_gc + 2) n_on = 1'b0;
    if (p_on && p_done >= 0 && c > p_done) p_on = 1'b0;
    wn = 0; wp = 0; vf = 0; ff = 0;
    va = raddr();
    case (mode)
      0: begin vf = (k == 10); if (k == 10) va = 19'h00123; end
      1: wn = (n_seq < 8);
      2: begin wn = 1; wp = 1; vf = (k == 5) || (k > 5 && k % 9 == 0); end
      3: begin vf = (k == 3) || (k == 4); if (k == 3) va = 19'h00777; end
      4: begin
        wn = ($urandom_range(0, 2) == 0);
        wp = ($urandom_range(0, 2) == 0);
        vf = ($urandom_range(0, 3) == 0);
        ff = ($urandom_range(0, 15) == 0);
      end
      default: ;
    endcase
    if (!n_on && wn) begin
      n_on = 1; n_gc = -1;
      n_addr = (mode == 1) ? AW'(n_seq) : raddr();
      n_seq++;
      n_data = rdat();
    end
    if (!p_on && wp) begin
      p_on = 1; p_done = -1;
      p_wr = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      p_addr_m = raddr();
      p_wd = rdat();
    end
    frame_flag = ff;
    vga_flag   = vf;
    vga_addr   = va;
    ntsc_flag  = n_on;
    ntsc_addr  = n_on ? n_addr : raddr();
    ntsc_data  = n_on ? n_data : rdat();
    pt_flag    = p_on;
    pt_we      = p_on ? p_wr : 1'($urandom_range(0, 1));
    pt_addr    = p_on ? p_addr_m : raddr();
    pt_wdata   = p_on ? p_wd : rdat();

    // One VGA read may be outstanding; extra flags before its done are dropped.
    win = 0;
    vpend = (c <= vga_last + LAT + 1);
    if (vf) begin
      if (vpend) begin
        if (ovr_cyc < 0) ovr_cyc = c + 1;
      end else begin
        win = 1;
      end
    end
    n_ok = n_on && n_gc < 0;
    p_ok = p_on && p_done < 0;
    if (win == 0) begin
      if (n_ok && p_ok) win = last_pt ? 2 : 3;
      else if (n_ok) win = 2;
      else if (p_ok) win = 3;
    end
    case (win)
      1: begin
        vga_last = c;
        ea = eff(va, 1'b0);
        q_mem.push_back('{c + 1, 1'b0, ea, '0});
        q_vga.push_back('{c + LAT + 2, 1'b1, hashf(ea)});
      end
      2: begin
        n_gc = c; last_pt = 0;
        q_mem.push_back('{c + 1, 1'b1, eff(n_addr, 1'b1), n_data});
        q_nd.push_back(c + 1);
      end
      3: begin
        last_pt = 1;
        if (p_wr) begin
          p_done = c + 1;
          q_mem.push_back('{c + 1, 1'b1, eff(p_addr_m, 1'b1), p_wd});
          q_pt.push_back('{c + 1, 1'b0, '0});
        end else begin
          p_done = c + LAT + 2;
          ea = eff(p_addr_m, 1'b0);
          q_mem.push_back('{c + 1, 1'b0, ea, '0});
          q_pt.push_back('{p_done, 1'b1, hashf(ea)});
        end
      end
      default: ;
    endcase
    if (SWAP && ff) m_bank = ~m_bank;
  endtask

  task automatic run_cycles(int mode, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      drive_one(mode, k);
    end
  endtask

  always @(negedge clock) begin
    bit        p;
    mem_exp_t  me;
    done_exp_t de;
    if (sb_on) begin
      p = (q_mem.size() > 0) && (q_mem[0].cyc == cyc);
      chk("mem_cen", 64'(mem_cen), 64'(p));
      if (p) begin
        me = q_mem.pop_front();
        chk("mem_we", 64'(mem_we), 64'(me.we));
        chk("mem_addr", 64'(mem_addr), 64'(me.addr));
        if (me.we) chk("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
      end
      p = (q_nd.size() > 0) && (q_nd[0] == cyc);
      chk("done_ntsc", 64'(done_ntsc), 64'(p));
      if (p) void'(q_nd.pop_front());
      p = (q_vga.size() > 0) && (q_vga[0].cyc == cyc);
      chk("done_vga", 64'(done_vga), 64'(p));
      if (p) begin
        de = q_vga.pop_front();
        chk("vga_pixel", 64'(vga_pixel), 64'(de.data));
      end
      p = (q_pt.size() > 0) && (q_pt[0].cyc == cyc);
      chk("done_pt", 64'(done_pt), 64'(p));
      if (p) begin
        de = q_pt.pop_front();
        if (de.rd) chk("pt_rdata", 64'(pt_rdata), 64'(de.data));
      end
      chk("vga_overrun", 64'(vga_overrun), 64'(ovr_cyc >= 0 && cyc >= ovr_cyc));
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_mem_cen"}, 64'(mem_cen), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_dones"}, 64'({done_vga, done_ntsc, done_pt}), 64'(0));
    chk({tag, "_vga_pixel"}, 64'(vga_pixel), 64'(0));
    chk({tag, "_pt_rdata"}, 64'(pt_rdata), 64'(0));
    chk({tag, "_overrun"}, 64'(vga_overrun), 64'(0));
  endtask

  initial begin
    int seen;
    frame_flag = 0; vga_flag = 0; ntsc_flag = 0; pt_flag = 0; pt_we = 0;
    vga_addr = '0; ntsc_addr = '0; pt_addr = '0; ntsc_data = '0; pt_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    sb_on = 1'b1;

    run_cycles(0, 30);
    run_cycles(1, 30);
    run_cycles(3, 15);
    run_cycles(2, 60);
    run_cycles(4, 1500);
    run_cycles(5, 20);
    @(negedge clock);
    #1;
    sb_on = 1'b0;
    chk("drained", 64'(q_mem.size() + q_vga.size() + q_pt.size() + q_nd.size()), 64'(0));

    // A transform read is in flight when reset hits; nothing may complete afterwards.
    @(posedge clock); #1;
    vga_flag = 0; ntsc_flag = 0; frame_flag = 0;
    pt_flag = 1; pt_we = 0; pt_addr = 19'h00456;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_issue_cen", 64'(mem_cen), 64'(1));
    chk("rst_issue_rd", 64'(mem_we), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    pt_flag = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (done_pt || done_vga || mem_cen) seen++;
    end
    chk("no_done_after_reset", 64'(seen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zbt_mem_arbiter.md
Name: zbt_mem_arbiter

Overview:
- Shares the single pipelined ZBT frame memory between three requesters: VGA readout, NTSC frame capture (write) and the projective-transform engine (read/write).
- VGA has strict priority and guaranteed latency so the display never starves.
- NTSC and transform requests share the remaining slots round-robin.
- Returns read data and done pulses in the same flag/done style the VGA writer already uses.

Parameters:
- ADDR_W, 19: memory word address width.
- DATA_W, 36: memory word width (two packed 18-bit YCrCb pixels).
- MEM_LAT, 2: cycles from issue on the mem_* port to valid mem_rdata. Must be at least 1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_flag  in  1  single-cycle pulse at the start of each video frame.
- vga_flag  in  1  single-cycle read request pulse.
- vga_addr  in  ADDR_W  VGA read address; valid with vga_flag.
- vga_pixel  out  DATA_W  VGA read data.
- done_vga  out  1  pulse; vga_pixel is valid.
- vga_overrun  out  1  sticky; a VGA request arrived while one was still pending.
- ntsc_flag  in  1  level write request; held until done_ntsc.
- ntsc_addr  in  ADDR_W  NTSC write address.
- ntsc_data  in  DATA_W  NTSC write data.
- done_ntsc  out  1  pulse; write issued.
- pt_flag  in  1  level request; held until done_pt.
- pt_we  in  1  1 = write, 0 = read.
- pt_addr  in  ADDR_W  transform engine address.
- pt_wdata  in  DATA_W  transform engine write data.
- pt_rdata  out  DATA_W  transform engine read data.
- done_pt  out  1  pulse; write issued, or read data valid.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_we  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_cen  out  1  registered; 1 = operation issued this cycle.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after issue.

Behaviour:
- Reset (reset low, asynchronous): every output is 0, the VGA pending latch is clear, the RR pointer favours NTSC, the tag pipeline is empty and the bank bit is 0.
- VGA latch: vga_flag sets vga_pend and captures vga_addr.
  - If vga_flag arrives while vga_pend=1: keep the original address, drop the new request, set vga_overrun (cleared only by reset).
- Arbitration is evaluated each cycle t. The winner is registered onto mem_* at the edge ending t, so the op is visible during t+1.
  - Priority 1: vga_pend, or vga_flag in cycle t itself (bypass). A VGA flag seen at t issues at t+1.
  - Priority 2: ntsc_flag and eligible pt_flag, chosen round-robin. The pointer toggles only on a grant to one of these two; if only one requests, it wins.
  - pt_flag is ineligible while its read is outstanding (granted, done_pt not yet pulsed).
  - ntsc_flag is ineligible in the cycle its done_ntsc pulses, so it is not issued twice.
  - No winner: mem_cen=0, mem_we=0, mem_addr/mem_wdata hold.
- Writes (NTSC, PT with pt_we=1): done pulses during the issue cycle t+1. The requester may reassert on t+2.
- Reads (VGA, PT with pt_we=0): a MEM_LAT-deep tag shift register records {valid, requester}. mem_rdata is captured into vga_pixel/pt_rdata at issue+MEM_LAT, and done pulses the following cycle.
  - Total VGA latency is flag→done = MEM_LAT+2 cycles (4 at default).
  - vga_pixel/pt_rdata hold between dones.
- Simultaneous: a VGA flag arriving in the same cycle a PT read returns has no conflict, because the return path and issue path are independent.
- Throughput: one operation per cycle maximum. Back-to-back reads may be in flight up to MEM_LAT deep.
- Reset mid-operation clears in-flight tags; no done pulses after reset release for ops issued before it.

Optional Feature:
- FRAME_SWAP_EN defined: a bank bit toggles on each frame_flag.
  - Effective address MSB is overridden: NTSC writes bank ~bank, VGA reads bank bank, PT reads bank bank and writes bank ~bank.
  - The toggle takes effect for ops arbitrated in the cycle after the frame_flag pulse.
- FRAME_SWAP_EN undefined: addresses pass through unmodified and frame_flag is ignored.

Test Plan:
- Lone VGA read: vga_flag at cycle 10, addr 0x00123, mem_rdata=0xABCDE at issue+2 → mem_cen=1/mem_we=0/mem_addr=0x00123 at cycle 11; done_vga=1 at cycle 14 with vga_pixel=0xABCDE.
- Contention: ntsc_flag and pt_flag (read) held, vga_flag at cycle 5 → cycle 6 issues VGA; remaining slots alternate NTSC, PT starting with NTSC after reset; PT is not reissued until done_pt.
- Overrun: vga_flag at cycles 3 and 4 with both NTSC and PT idle → second pulse latched only if the first already issued (bypass); force a stall scenario and check vga_overrun=1, first address kept.
- NTSC streaming: ntsc_flag held with addresses 0..7 advancing on each done_ntsc, no other requesters → one write every 2 cycles, data matches, no duplicate addresses.
- Reset mid-read: assert reset 1 cycle after a PT read issue → all outputs 0 immediately; after release, no done_pt pulse.
- FRAME_SWAP_EN: frame_flag pulse then NTSC write to 0x00010 and VGA read of 0x00010 → mem_addr MSBs differ (bank 1 vs 0); second frame_flag reverses them.
